gsim_mat_fetch: RTL and testbench
=================================

# gsim_mat_fetch

Matrix fetch unit for the GSIM solver. It sits between the external 256-bit matrix memory port and the Gauss-Seidel compute core. For one matrix it issues the 17 word reads using the memory's request/ready handshake and buffers the returned words in a credit-controlled FIFO. It then delivers them in order to the core as a valid/ready row stream.

## Interface
- FIFO_DEPTH, 4: buffered words; also the outstanding-request limit.
- WORDS_PER_MAT, 17: words per matrix (rows 0-15 = A rows, 16 x 16-bit coefficients each; word 16 = b vector).
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle start pulse; ignored unless IDLE.
- i_mat_idx  in  5  matrix index, latched on accepted start.
- i_mat_num  in  5  matrix count; used only with GSIM_FETCH_CHAIN_EN.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse after the last word of a matrix is consumed.
- o_err  out  1  sticky; set by a dout_vld with no outstanding request.
- o_mem_rreq  out  1  read request.
- o_mem_addr  out  10  word address.
- i_mem_rrdy  in  1  memory ready.
- i_mem_dout  in  256  read data.
- i_mem_dout_vld  in  1  read data valid.
- o_row_vld  out  1  row word available.
- i_row_rdy  in  1  core accepts the row word.
- o_row_data  out  256  FIFO head word.
- o_row_idx  out  5  word index 0..16 of the head word.
- o_row_last  out  1  head word is index 16.

## Operation
- States and transitions:
  - IDLE -> FETCH on i_start.
  - FETCH -> DRAIN when all 17 requests are accepted.
  - DRAIN -> DONE when the 17th word is popped.
  - DONE -> IDLE after one cycle.
- Base address = i_mat_idx*17, computed as (idx<<4)+idx, 10 bits. The maximum address, 31*17+16 = 543, never wraps.
- A request is accepted on a rising edge where o_mem_rreq && i_mem_rrdy.
  - o_mem_addr and o_mem_rreq must hold stable until the request is accepted.
  - The address increments by 1 per accepted request.
- Credit rule: o_mem_rreq = FETCH && (outstanding + fifo_count < FIFO_DEPTH).
  - outstanding increments on accept and decrements on dout_vld.
  - A simultaneous accept and return leaves outstanding unchanged.
- Returned data arrives in request order with variable latency. Each valid word is written to the FIFO. The credit rule guarantees the FIFO never overflows.
- dout_vld with outstanding == 0: the data is dropped and o_err is set. o_err is cleared only by reset.
- Stream side:
  - Pop when o_row_vld && i_row_rdy.
  - o_row_idx counts pops 0..16.
  - Simultaneous FIFO push and pop is legal at any fill level, including full and empty.
- i_start while busy is ignored.
- Reset mid-operation returns the block to IDLE and clears the FIFO and all counters. A stale dout_vld arriving after reset sets o_err.
- Reset values: o_busy, o_done, o_err, o_mem_rreq, o_row_vld, o_row_last = 0; o_mem_addr, o_row_idx, o_row_data = 0.

## Timing
- Start sampled at edge 0: o_mem_rreq is high from cycle 1 with o_mem_addr = base.
- FIFO write is registered and the FIFO is show-ahead. o_row_vld rises the cycle after the first dout_vld is sampled.
- With the memory delivering data 2 edges after accept, first o_row_vld occurs 3 cycles after the first accept.
- Steady-state throughput: 1 word/cycle when rrdy and row_rdy are held high and FIFO_DEPTH ≥ round-trip latency + 1.
- o_done asserts the cycle after the pop of word 16.

## Configuration
- GSIM_FETCH_CHAIN_EN defined: in DONE, if latched idx+1 < i_mat_num, the block reloads idx+1 and goes directly to FETCH (o_done still pulses, o_busy stays high). Otherwise it returns to IDLE.
- Macro undefined: i_mat_num is ignored and DONE always goes to IDLE.

## Structure
- The shared package gsim_pkg holds:
  - WORDS_PER_MAT and the address/data width constants;
  - the fetch state enum (IDLE, FETCH, DRAIN, DONE);
  - the row index type.
- One sub-module, gsim_sync_fifo: parameterised width/depth, show-ahead, with count output.

## Test plan
- idx=0, rrdy=1, row_rdy=1 -> addresses 0..16 on consecutive cycles, 17 pops with idx 0..16, last on 16, o_done 1 cycle after.
- idx=30 -> first address 510, last 526, no wrap.
- rrdy random (seed 0), row_rdy=0 for 20 cycles -> at most 4 outstanding+buffered, rreq low while no credit, addr held until accepted, data order preserved.
- Spurious dout_vld while IDLE -> o_err=1, FIFO count stays 0, stays set until reset.
- Reset asserted after 5 accepts -> next cycle all outputs at reset values, new start for idx=2 fetches addresses 34..50 cleanly.
- GSIM_FETCH_CHAIN_EN, idx=0, i_mat_num=3 -> three o_done pulses, addresses 0..50 contiguous, o_busy continuous, then IDLE.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared constants and types for the GSIM matrix fetch path.
package gsim_pkg;

    localparam int unsigned WORDS_PER_MAT = 17;
    localparam int unsigned ADDR_W        = 10;
    localparam int unsigned DATA_W        = 256;
    localparam int unsigned IDX_W         = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } fetch_state_e;

    // Word index within a matrix: 0..15 are A rows, 16 is the b vector.
    typedef logic [IDX_W-1:0] row_idx_t;

    localparam row_idx_t LAST_ROW_IDX = row_idx_t'(WORDS_PER_MAT - 1);

    // idx*17 without a multiplier; 31*17+16 = 543 fits in 10 bits.
    function automatic logic [ADDR_W-1:0] mat_base(input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] wide;
        wide = ADDR_W'(idx);
        return (wide << 4) + wide;
    endfunction

endpackage

// File: rtl/gsim_sync_fifo.sv
// Show-ahead synchronous FIFO with a fill count; the head word is visible on rdata_o
// whenever empty_o is low. Push and pop in the same cycle are legal at any fill level.
module gsim_sync_fifo #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full, do_push, do_pop;

    // Pointer/count next state; a push into a full FIFO only lands if a pop frees the slot.
    always_comb begin
        full     = (count_q == CntW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    // Storage and pointers; reset also clears storage so the head reads zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Show-ahead outputs.
    always_comb begin
        rdata_o = mem_q[rd_ptr_q];
        empty_o = (count_q == '0);
        count_o = count_q;
    end

endmodule

// File: rtl/gsim_mat_fetch.sv
// Matrix fetch unit: issues the 17 word reads of one matrix under a credit limit, buffers
// returns in a FIFO and streams them to the core with word index and last flag.
// Optional feature macro: GSIM_FETCH_CHAIN_EN (chain to the next matrix index from DONE).
module gsim_mat_fetch
    import gsim_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [IDX_W-1:0]  i_mat_idx,
    input  logic [IDX_W-1:0]  i_mat_num,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_mem_rreq,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_rrdy,
    input  logic [DATA_W-1:0] i_mem_dout,
    input  logic              i_mem_dout_vld,
    output logic              o_row_vld,
    input  logic              i_row_rdy,
    output logic [DATA_W-1:0] o_row_data,
    output row_idx_t          o_row_idx,
    output logic              o_row_last
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SumW = CntW + 1;

    fetch_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    row_idx_t          req_cnt_q, req_cnt_d;
    row_idx_t          pop_cnt_q, pop_cnt_d;
    logic [CntW-1:0]   outst_q, outst_d;
    logic              err_q, err_d;

    logic [CntW-1:0]   fifo_count;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              credit_ok, rreq, accept, ret_ok, spurious, row_vld, pop;
    logic [IDX_W:0]    next_idx_w;

`ifndef GSIM_FETCH_CHAIN_EN
    logic unused_mat_num;
    assign unused_mat_num = ^i_mat_num;
`endif

    // Handshake decode; in-flight plus buffered words never exceed the FIFO depth.
    always_comb begin
        credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < SumW'(FIFO_DEPTH);
        rreq      = (state_q == StFetch) && credit_ok;
        accept    = rreq && i_mem_rrdy;
        ret_ok    = i_mem_dout_vld && (outst_q != '0);
        spurious  = i_mem_dout_vld && (outst_q == '0);
        row_vld   = !fifo_empty;
        pop       = row_vld && i_row_rdy;
    end

    // FSM next state and counters.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        req_cnt_d  = req_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        outst_d    = outst_q + CntW'(accept) - CntW'(ret_ok);
        err_d      = err_q | spurious;
        next_idx_w = {1'b0, idx_q} + 1'b1;

        if (pop) begin
            pop_cnt_d = (pop_cnt_q == LAST_ROW_IDX) ? '0 : pop_cnt_q + row_idx_t'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d   = StFetch;
                    idx_d     = i_mat_idx;
                    addr_d    = mat_base(i_mat_idx);
                    req_cnt_d = '0;
                    pop_cnt_d = '0;
                end
            end
            StFetch: begin
                if (accept) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    req_cnt_d = req_cnt_q + row_idx_t'(1);
                    if (req_cnt_q == LAST_ROW_IDX) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && (pop_cnt_q == LAST_ROW_IDX)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
`ifdef GSIM_FETCH_CHAIN_EN
                if (next_idx_w < {1'b0, i_mat_num}) begin
                    state_d   = StFetch;
                    idx_d     = next_idx_w[IDX_W-1:0];
                    addr_d    = mat_base(next_idx_w[IDX_W-1:0]);
                    req_cnt_d = '0;
                    pop_cnt_d = '0;
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            addr_q    <= '0;
            req_cnt_q <= '0;
            pop_cnt_q <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            req_cnt_q <= req_cnt_d;
            pop_cnt_q <= pop_cnt_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    gsim_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .push_i  (ret_ok),
        .wdata_i (i_mem_dout),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Output mapping.
    always_comb begin
        o_busy     = (state_q != StIdle);
        o_done     = (state_q == StDone);
        o_err      = err_q;
        o_mem_rreq = rreq;
        o_mem_addr = addr_q;
        o_row_vld  = row_vld;
        o_row_data = fifo_rdata;
        o_row_idx  = pop_cnt_q;
        o_row_last = row_vld && (pop_cnt_q == LAST_ROW_IDX);
    end

endmodule

// File: tb/tb_gsim_mat_fetch.sv
// Self-checking bench for gsim_mat_fetch: randomized memory latency/ready and core ready,
// checked against a behavioural model of addresses, word order, credits and done pulses.
module tb_gsim_mat_fetch;

    localparam int DEPTH = 4;
    localparam int WPM   = 17;

    logic         clk;
    logic         i_reset, i_start, i_mem_rrdy, i_mem_dout_vld, i_row_rdy;
    logic [4:0]   i_mat_idx, i_mat_num;
    logic         o_busy, o_done, o_err, o_mem_rreq, o_row_vld, o_row_last;
    logic [9:0]   o_mem_addr;
    logic [255:0] i_mem_dout, o_row_data;
    logic [4:0]   o_row_idx;

    gsim_mat_fetch #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_mat_idx      (i_mat_idx),
        .i_mat_num      (i_mat_num),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_mem_rreq     (o_mem_rreq),
        .o_mem_addr     (o_mem_addr),
        .i_mem_rrdy     (i_mem_rrdy),
        .i_mem_dout     (i_mem_dout),
        .i_mem_dout_vld (i_mem_dout_vld),
        .o_row_vld      (o_row_vld),
        .i_row_rdy      (i_row_rdy),
        .o_row_data     (o_row_data),
        .o_row_idx      (o_row_idx),
        .o_row_last     (o_row_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [9:0] addr; int due;} req_t;
    typedef struct {logic [255:0] data; logic [4:0] idx; logic last; int e;} pop_t;

    int n_cmp = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Memory / core behaviour knobs.
    int  lat_min = 2, lat_max = 2;
    bit  rrdy_rand = 0, rowrdy_rand = 0, spur = 0;
    int  block_cycles = 0, rowrdy_block_until = 0, restart_at = -1;
    logic [31:0] salt = 32'h0;

    // Model state and logs.
    req_t        pend_q[$];
    logic [9:0]  acc_addr_q[$];
    int          acc_edge_q[$];
    pop_t        pop_q[$];
    int          done_edges[$];
    int          model_out = 0, model_buf = 0;
    int          viol_credit = 0, viol_hold = 0, viol_vld = 0;
    bit          hold_pending = 0;
    logic [9:0]  hold_addr = '0;

    function automatic logic [255:0] data_of(input logic [9:0] a);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) begin
            d[i*32 +: 32] = ({22'd0, a} * 32'h9E37_79B1) ^ (32'(i) * 32'h85EB_CA6B) ^ salt;
        end
        return d;
    endfunction

    task automatic clear_logs();
        acc_addr_q.delete();
        acc_edge_q.delete();
        pop_q.delete();
        done_edges.delete();
        viol_credit = 0;
        viol_hold = 0;
        viol_vld = 0;
    endtask

    // One clock: drive memory/core inputs at negedge, observe, update model, pass the edge.
    task automatic tick();
        req_t r;
        pop_t p;
        bit   ret, acc, pp;
        @(negedge clk);
        ret = 0;
        i_mem_dout_vld = 1'b0;
        i_mem_dout = '0;
        i_mem_rrdy = rrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        i_row_rdy = (edge_n < rowrdy_block_until) ? 1'b0 :
                    (rowrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (i_reset) begin
            pend_q.delete();
            model_out = 0;
            model_buf = 0;
            hold_pending = 0;
            spur = 0;
        end else begin
            if (spur) begin
                i_mem_dout_vld = 1'b1;
                i_mem_dout = data_of(10'h3ff);
                spur = 0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= edge_n) begin
                r = pend_q.pop_front();
                i_mem_dout_vld = 1'b1;
                i_mem_dout = data_of(r.addr);
                ret = 1;
            end
            if (o_mem_rreq && (model_out + model_buf >= DEPTH)) viol_credit++;
            if (model_out + model_buf > DEPTH) viol_credit++;
            if (hold_pending && (!o_mem_rreq || o_mem_addr !== hold_addr)) viol_hold++;
            if (o_row_vld !== (model_buf > 0)) viol_vld++;
            if (o_row_last !== (o_row_vld && o_row_idx == 5'd16)) viol_vld++;
            acc = o_mem_rreq && i_mem_rrdy;
            if (acc) begin
                acc_addr_q.push_back(o_mem_addr);
                acc_edge_q.push_back(edge_n);
                r.addr = o_mem_addr;
                r.due = edge_n + $urandom_range(lat_min, lat_max);
                pend_q.push_back(r);
            end
            hold_pending = o_mem_rreq && !i_mem_rrdy;
            hold_addr = o_mem_addr;
            pp = o_row_vld && i_row_rdy;
            if (pp) begin
                p.data = o_row_data;
                p.idx = o_row_idx;
                p.last = o_row_last;
                p.e = edge_n;
                pop_q.push_back(p);
            end
            if (o_done) done_edges.push_back(edge_n);
            model_out += int'(acc) - int'(ret);
            model_buf += int'(ret) - int'(pp);
        end
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Start one fetch and run until o_busy falls or the budget runs out.
    task automatic run_matrix(input logic [4:0] idx, input logic [4:0] num, input int budget,
                              output bit to, output int s);
        clear_logs();
        i_mat_idx = idx;
        i_mat_num = num;
        i_start = 1'b1;
        s = edge_n;
        rowrdy_block_until = edge_n + block_cycles;
        tick();
        i_start = 1'b0;
        i_mat_idx = 5'($urandom);
        to = 1;
        for (int c = 0; c < budget; c++) begin
            i_start = (c == restart_at);
            tick();
            i_start = 1'b0;
            if (!o_busy) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", o_done); end
        n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", o_err); end
        n_cmp++; if (o_mem_rreq !== 1'b0) begin n_fail++; $display("FAIL rst_rreq got %b want 0", o_mem_rreq); end
        n_cmp++; if (o_mem_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", o_mem_addr); end
        n_cmp++; if (o_row_vld !== 1'b0) begin n_fail++; $display("FAIL rst_row_vld got %b want 0", o_row_vld); end
        n_cmp++; if (o_row_last !== 1'b0) begin n_fail++; $display("FAIL rst_row_last got %b want 0", o_row_last); end
        n_cmp++; if (o_row_idx !== 5'd0) begin n_fail++; $display("FAIL rst_row_idx got %0d want 0", o_row_idx); end
        n_cmp++; if (o_row_data !== 256'd0) begin n_fail++; $display("FAIL rst_row_data got %h want 0", o_row_data); end
        i_reset = 1'b0;
        tick();
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got %b want 0", o_busy); end
    endtask

    task automatic test_idx0_stream();
        bit to;
        int s;
        salt = 32'h1111_0000; lat_min = 2; lat_max = 2;
        rrdy_rand = 0; rowrdy_rand = 0; block_cycles = 0; restart_at = -1;
        run_matrix(5'd0, 5'd1, 200, to, s);
        n_cmp++; if (to) begin n_fail++; $display("FAIL idx0_timeout busy=%b want 0", o_busy); end
        n_cmp++; if (acc_addr_q.size() != WPM) begin
            n_fail++; $display("FAIL idx0_acc_cnt got %0d want %0d", acc_addr_q.size(), WPM); end
        for (int k = 0; k < acc_addr_q.size() && k < WPM; k++) begin
            n_cmp++; if (acc_addr_q[k] !== 10'(k)) begin
                n_fail++; $display("FAIL idx0_addr[%0d] got %0d want %0d", k, acc_addr_q[k], k); end
            n_cmp++; if (acc_edge_q[k] != s + 1 + k) begin
                n_fail++; $display("FAIL idx0_acc_edge[%0d] got %0d want %0d", k, acc_edge_q[k], s + 1 + k); end
        end
        n_cmp++; if (pop_q.size() != WPM) begin
            n_fail++; $display("FAIL idx0_pop_cnt got %0d want %0d", pop_q.size(), WPM); end
        for (int k = 0; k < pop_q.size() && k < WPM; k++) begin
            n_cmp++; if (pop_q[k].data !== data_of(10'(k))) begin
                n_fail++; $display("FAIL idx0_data[%0d] got %h want %h", k, pop_q[k].data, data_of(10'(k))); end
            n_cmp++; if (pop_q[k].idx !== 5'(k) || pop_q[k].last !== (k == WPM - 1)) begin
                n_fail++; $display("FAIL idx0_idx_last[%0d] got %0d/%b want %0d/%b", k, pop_q[k].idx,
                                   pop_q[k].last, k, k == WPM - 1); end
            n_cmp++; if (pop_q[k].e != s + 4 + k) begin
                n_fail++; $display("FAIL idx0_pop_edge[%0d] got %0d want %0d", k, pop_q[k].e, s + 4 + k); end
        end
        n_cmp++; if (done_edges.size() != 1) begin
            n_fail++; $display("FAIL idx0_done_cnt got %0d want 1", done_edges.size()); end
        else begin
            n_cmp++; if (done_edges[0] != s + 21) begin
                n_fail++; $display("FAIL idx0_done_edge got %0d want %0d", done_edges[0], s + 21); end
        end
        n_cmp++; if (viol_credit + viol_hold + viol_vld != 0) begin
            n_fail++; $display("FAIL idx0_viol got %0d/%0d/%0d want 0", viol_credit, viol_hold, viol_vld); end
        n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL idx0_err got %b want 0", o_err); end
    endtask

    // Highest index, random latency/back-pressure, and a start pulse while busy.
    task automatic test_idx30();
        bit to;
        int s;
        salt = 32'h2222_0303; lat_min = 1; lat_max = 3;
        rrdy_rand = 1; rowrdy_rand = 1; block_cycles = 0; restart_at = 5;
        run_matrix(5'd30, 5'd1, 400, to, s);
        restart_at = -1;
        n_cmp++; if (to) begin n_fail++; $display("FAIL idx30_timeout busy=%b want 0", o_busy); end
        n_cmp++; if (acc_addr_q.size() != WPM) begin
            n_fail++; $display("FAIL idx30_acc_cnt got %0d want %0d", acc_addr_q.size(), WPM); end
        for (int k = 0; k < acc_addr_q.size() && k < WPM; k++) begin
            n_cmp++; if (acc_addr_q[k] !== 10'(30 * 17 + k)) begin
                n_fail++; $display("FAIL idx30_addr[%0d] got %0d want %0d", k, acc_addr_q[k], 510 + k); end
        end
        n_cmp++; if (pop_q.size() != WPM) begin
            n_fail++; $display("FAIL idx30_pop_cnt got %0d want %0d", pop_q.size(), WPM); end
        for (int k = 0; k < pop_q.size() && k < WPM; k++) begin
            n_cmp++; if (pop_q[k].data !== data_of(10'(510 + k)) || pop_q[k].idx !== 5'(k)) begin
                n_fail++; $display("FAIL idx30_pop[%0d] got idx %0d data %h want idx %0d", k, pop_q[k].idx,
                                   pop_q[k].data, k); end
        end
        n_cmp++; if (done_edges.size() != 1) begin
            n_fail++; $display("FAIL idx30_done_cnt got %0d want 1", done_edges.size()); end
        n_cmp++; if (viol_credit + viol_hold + viol_vld != 0) begin
            n_fail++; $display("FAIL idx30_viol got %0d/%0d/%0d want 0", viol_credit, viol_hold, viol_vld); end
    endtask

    // Core stalled 20 cycles at the start: credit must cap in-flight plus buffered words.
    task automatic test_credit_random();
        bit to;
        int s;
        logic [4:0] idx;
        lat_min = 1; lat_max = 4; rrdy_rand = 1; rowrdy_rand = 1; block_cycles = 20;
        restart_at = -1;
        for (int it = 0; it < 3; it++) begin
            salt = $urandom;
            idx = 5'($urandom_range(0, 31));
            run_matrix(idx, 5'd1, 600, to, s);
            n_cmp++; if (to) begin n_fail++; $display("FAIL credit_timeout[%0d] busy=%b want 0", it, o_busy); end
            n_cmp++; if (viol_credit != 0) begin
                n_fail++; $display("FAIL credit_limit[%0d] got %0d violations want 0", it, viol_credit); end
            n_cmp++; if (viol_hold != 0) begin
                n_fail++; $display("FAIL credit_hold[%0d] got %0d violations want 0", it, viol_hold); end
            n_cmp++; if (viol_vld != 0) begin
                n_fail++; $display("FAIL credit_vld[%0d] got %0d violations want 0", it, viol_vld); end
            n_cmp++; if (acc_addr_q.size() != WPM || pop_q.size() != WPM) begin
                n_fail++; $display("FAIL credit_counts[%0d] got %0d/%0d want %0d/%0d", it,
                                   acc_addr_q.size(), pop_q.size(), WPM, WPM); end
            for (int k = 0; k < pop_q.size() && k < WPM; k++) begin
                n_cmp++; if (pop_q[k].data !== data_of(10'(int'(idx) * 17 + k))
                             || pop_q[k].idx !== 5'(k) || pop_q[k].last !== (k == WPM - 1)) begin
                    n_fail++; $display("FAIL credit_pop[%0d][%0d] got idx %0d last %b", it, k,
                                       pop_q[k].idx, pop_q[k].last); end
            end
        end
        block_cycles = 0;
    endtask

    task automatic test_spurious();
        bit to;
        int s;
        salt = 32'h5555_AAAA; lat_min = 2; lat_max = 2; rrdy_rand = 0; rowrdy_rand = 0;
        spur = 1;
        tick();
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (o_err !== 1'b1 || o_row_vld !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++; $display("FAIL spur_idle[%0d] got err %b vld %b busy %b want 1 0 0", c, o_err,
                                   o_row_vld, o_busy); end
            tick();
        end
        run_matrix(5'd9, 5'd1, 200, to, s);
        n_cmp++; if (to || pop_q.size() != WPM) begin
            n_fail++; $display("FAIL spur_fetch got to %b pops %0d want 0 %0d", to, pop_q.size(), WPM); end
        n_cmp++; if (pop_q.size() > 0 && pop_q[0].data !== data_of(10'd153)) begin
            n_fail++; $display("FAIL spur_first_data got %h want %h", pop_q[0].data, data_of(10'd153)); end
        n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky got %b want 1", o_err); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL spur_clear got %b want 0", o_err); end
        spur = 1;
        tick();
        n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL spur_stale got %b want 1", o_err); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit to;
        int s;
        salt = 32'h7777_1234; lat_min = 2; lat_max = 2; rrdy_rand = 0; rowrdy_rand = 0;
        clear_logs();
        i_mat_idx = 5'd20;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        to = 1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (acc_addr_q.size() >= 5) begin
                to = 0;
                break;
            end
        end
        n_cmp++; if (to) begin n_fail++; $display("FAIL mid_wait got %0d accepts want 5", acc_addr_q.size()); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        n_cmp++; if ({o_busy, o_done, o_err, o_mem_rreq, o_row_vld, o_row_last} !== 6'd0) begin
            n_fail++; $display("FAIL mid_rst_flags got %b want 000000",
                               {o_busy, o_done, o_err, o_mem_rreq, o_row_vld, o_row_last}); end
        n_cmp++; if (o_mem_addr !== 10'd0 || o_row_idx !== 5'd0 || o_row_data !== 256'd0) begin
            n_fail++; $display("FAIL mid_rst_values got addr %0d idx %0d data %h want 0", o_mem_addr,
                               o_row_idx, o_row_data); end
        run_matrix(5'd2, 5'd1, 200, to, s);
        n_cmp++; if (to || acc_addr_q.size() != WPM || pop_q.size() != WPM) begin
            n_fail++; $display("FAIL mid_refetch got to %b acc %0d pops %0d want 0 17 17", to,
                               acc_addr_q.size(), pop_q.size()); end
        for (int k = 0; k < acc_addr_q.size() && k < WPM; k++) begin
            n_cmp++; if (acc_addr_q[k] !== 10'(34 + k)) begin
                n_fail++; $display("FAIL mid_addr[%0d] got %0d want %0d", k, acc_addr_q[k], 34 + k); end
        end
        for (int k = 0; k < pop_q.size() && k < WPM; k++) begin
            n_cmp++; if (pop_q[k].data !== data_of(10'(34 + k)) || pop_q[k].idx !== 5'(k)) begin
                n_fail++; $display("FAIL mid_pop[%0d] got idx %0d want %0d", k, pop_q[k].idx, k); end
        end
        n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL mid_err got %b want 0", o_err); end
    endtask

    // i_mat_num=3 from idx 0: three matrices when chaining is built in, else one.
    task automatic test_chain();
        bit to;
        int s, mats;
`ifdef GSIM_FETCH_CHAIN_EN
        mats = 3;
`else
        mats = 1;
`endif
        salt = 32'h0C0A_1100; lat_min = 1; lat_max = 3; rrdy_rand = 1; rowrdy_rand = 1;
        run_matrix(5'd0, 5'd3, 1500, to, s);
        n_cmp++; if (to) begin n_fail++; $display("FAIL chain_timeout busy=%b want 0", o_busy); end
        n_cmp++; if (done_edges.size() != mats) begin
            n_fail++; $display("FAIL chain_done_cnt got %0d want %0d", done_edges.size(), mats); end
        n_cmp++; if (acc_addr_q.size() != WPM * mats || pop_q.size() != WPM * mats) begin
            n_fail++; $display("FAIL chain_counts got %0d/%0d want %0d", acc_addr_q.size(),
                               pop_q.size(), WPM * mats); end
        for (int k = 0; k < acc_addr_q.size() && k < WPM * mats; k++) begin
            n_cmp++; if (acc_addr_q[k] !== 10'(k)) begin
                n_fail++; $display("FAIL chain_addr[%0d] got %0d want %0d", k, acc_addr_q[k], k); end
        end
        for (int k = 0; k < pop_q.size() && k < WPM * mats; k++) begin
            n_cmp++; if (pop_q[k].data !== data_of(10'(k)) || pop_q[k].idx !== 5'(k % WPM)) begin
                n_fail++; $display("FAIL chain_pop[%0d] got idx %0d want %0d", k, pop_q[k].idx, k % WPM); end
        end
        n_cmp++; if (viol_credit + viol_hold + viol_vld != 0) begin
            n_fail++; $display("FAIL chain_viol got %0d/%0d/%0d want 0", viol_credit, viol_hold, viol_vld); end
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_mat_idx = '0;
        i_mat_num = '0;
        i_mem_rrdy = 1'b0;
        i_mem_dout = '0;
        i_mem_dout_vld = 1'b0;
        i_row_rdy = 1'b0;
        test_reset();
        test_idx0_stream();
        test_idx30();
        test_credit_random();
        test_spurious();
        test_reset_mid();
        test_chain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
